// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access order, FSM states and read/write direction.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_ORDER_BYTE = 2'd0,
    LSU_ORDER_HALF = 2'd1,
    LSU_ORDER_WORD = 2'd2,
    LSU_ORDER_RSVD = 2'd3
  } lsu_order_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic LSU_RW_LOAD  = 1'b0;
  localparam logic LSU_RW_STORE = 1'b1;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for big-endian accesses: byte mask, store-lane placement,
// misalignment detection, and load lane extraction with sign/zero extension.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_order,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  mask,
  output logic [31:0] st_lane_data,
  output logic        misaligned,
  input  logic [1:0]  ld_order,
  input  logic [1:0]  ld_offset,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_value
);

  // Extend a 16-bit lane to 32 bits; for byte lanes only the low 8 bits are meaningful.
  function automatic logic [31:0] extend_lane(input logic [15:0] lane, input logic is_half,
                                              input logic sgn);
    logic signed [31:0] ext;
    if (is_half) begin
      ext = sgn ? 32'(signed'(lane)) : {16'h0000, lane};
    end else begin
      ext = sgn ? 32'(signed'(lane[7:0])) : {24'h000000, lane[7:0]};
    end
    return ext;
  endfunction

  // Store side: address byte 0 lives in data[31:24], so byte lane index is (3 - offset).
  always_comb begin
    mask         = 4'b0000;
    st_lane_data = 32'h0000_0000;
    misaligned   = 1'b0;
    case (st_order)
      LSU_ORDER_BYTE: begin
        mask         = 4'b1000 >> st_offset;
        st_lane_data = {24'h000000, st_data[7:0]} << {~st_offset, 3'b000};
      end
      LSU_ORDER_HALF: begin
        misaligned   = st_offset[0];
        mask         = st_offset[1] ? 4'b0011 : 4'b1100;
        st_lane_data = st_offset[1] ? {16'h0000, st_data[15:0]} : {st_data[15:0], 16'h0000};
      end
      LSU_ORDER_WORD: begin
        misaligned   = |st_offset;
        mask         = 4'b1111;
        st_lane_data = st_data;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Load side: pick the addressed lane out of the returned word, then extend.
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte  = ld_word[{~ld_offset, 3'b000} +: 8];
    ld_half  = ld_offset[1] ? ld_word[15:0] : ld_word[31:16];
    ld_value = ld_word;
    case (ld_order)
      LSU_ORDER_BYTE: ld_value = extend_lane({8'h00, ld_byte}, 1'b0, ld_signed);
      LSU_ORDER_HALF: ld_value = extend_lane(ld_half, 1'b1, ld_signed);
      default:        ld_value = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from execute, drives the cache LDST
// handshake, and returns a registered writeback or a misalignment fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int P_HIT_CNT_WIDTH = 16
) (
  input  logic                       iCLOCK,
  input  logic                       inRESET,
  input  logic                       iRESET_SYNC,
  input  logic                       iEXE_REQ,
  output logic                       oEXE_BUSY,
  input  logic [1:0]                 iEXE_ORDER,
  input  logic                       iEXE_SIGNED,
  input  logic                       iEXE_RW,
  input  logic [31:0]                iEXE_ADDR,
  input  logic [31:0]                iEXE_DATA,
  input  logic [4:0]                 iEXE_DEST,
  output logic                       oLDST_REQ,
  input  logic                       iLDST_BUSY,
  output logic [1:0]                 oLDST_ORDER,
  output logic [3:0]                 oLDST_MASK,
  output logic                       oLDST_RW,
  output logic [31:0]                oLDST_ADDR,
  output logic [31:0]                oLDST_DATA,
  input  logic                       iLDST_VALID,
  input  logic                       iLDST_CACHE_HIT,
  input  logic [31:0]                iLDST_DATA,
  output logic                       oWB_VALID,
  output logic                       oWB_WRITE,
  output logic [4:0]                 oWB_DEST,
  output logic [31:0]                oWB_DATA,
  output logic                       oFAULT_VALID,
  output logic [31:0]                oFAULT_ADDR,
  output logic [P_HIT_CNT_WIDTH-1:0] oHIT_COUNT
);

  lsu_state_e                 state;
  logic                       ldst_req;
  logic [1:0]                 ldst_order;
  logic [3:0]                 ldst_mask;
  logic                       ldst_rw;
  logic [31:0]                ldst_addr;
  logic [31:0]                ldst_data;
  logic                       lat_signed;
  logic [4:0]                 lat_dest;
  logic                       wb_valid;
  logic                       wb_write;
  logic [4:0]                 wb_dest;
  logic [31:0]                wb_data;
  logic                       fault_valid;
  logic [31:0]                fault_addr;
  logic [P_HIT_CNT_WIDTH-1:0] hit_count;

  logic [3:0]                 mask;
  logic [31:0]                st_lane_data;
  logic                       misaligned;
  logic [31:0]                ld_value;

  // Store-side inputs come straight from execute; load-side inputs from the latched request.
  load_store_align u_align (
    .st_order     (iEXE_ORDER),
    .st_offset    (iEXE_ADDR[1:0]),
    .st_data      (iEXE_DATA),
    .mask         (mask),
    .st_lane_data (st_lane_data),
    .misaligned   (misaligned),
    .ld_order     (ldst_order),
    .ld_offset    (ldst_addr[1:0]),
    .ld_signed    (lat_signed),
    .ld_word      (iLDST_DATA),
    .ld_value     (ld_value)
  );

  // Access FSM with registered cache request, writeback, fault and hit counter.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= IDLE;
      ldst_req    <= 1'b0;
      ldst_order  <= 2'b00;
      ldst_mask   <= 4'b0000;
      ldst_rw     <= 1'b0;
      ldst_addr   <= 32'h0;
      ldst_data   <= 32'h0;
      lat_signed  <= 1'b0;
      lat_dest    <= 5'd0;
      wb_valid    <= 1'b0;
      wb_write    <= 1'b0;
      wb_dest     <= 5'd0;
      wb_data     <= 32'h0;
      fault_valid <= 1'b0;
      fault_addr  <= 32'h0;
      hit_count   <= '0;
    end else if (iRESET_SYNC) begin
      state       <= IDLE;
      ldst_req    <= 1'b0;
      ldst_order  <= 2'b00;
      ldst_mask   <= 4'b0000;
      ldst_rw     <= 1'b0;
      ldst_addr   <= 32'h0;
      ldst_data   <= 32'h0;
      lat_signed  <= 1'b0;
      lat_dest    <= 5'd0;
      wb_valid    <= 1'b0;
      wb_write    <= 1'b0;
      wb_dest     <= 5'd0;
      wb_data     <= 32'h0;
      fault_valid <= 1'b0;
      fault_addr  <= 32'h0;
      hit_count   <= '0;
    end else begin
      fault_valid <= 1'b0;
      wb_valid    <= 1'b0;
      wb_write    <= 1'b0;
      case (state)
        IDLE: begin
          // A request during the fault pulse is refused because oEXE_BUSY is high.
          if (iEXE_REQ && !fault_valid) begin
            if (misaligned) begin
              fault_valid <= 1'b1;
              fault_addr  <= iEXE_ADDR;
            end else begin
              ldst_req   <= 1'b1;
              ldst_order <= iEXE_ORDER;
              ldst_mask  <= mask;
              ldst_rw    <= iEXE_RW;
              ldst_addr  <= iEXE_ADDR;
              ldst_data  <= st_lane_data;
              lat_signed <= iEXE_SIGNED;
              lat_dest   <= iEXE_DEST;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (!iLDST_BUSY) begin
            ldst_req <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (iLDST_VALID) begin
            wb_valid <= 1'b1;
            wb_write <= (ldst_rw == LSU_RW_LOAD);
            wb_dest  <= lat_dest;
            wb_data  <= (ldst_rw == LSU_RW_LOAD) ? ld_value : 32'h0;
            if ((ldst_rw == LSU_RW_LOAD) && iLDST_CACHE_HIT && (hit_count != '1)) begin
              hit_count <= hit_count + 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oEXE_BUSY    = (state != IDLE) | fault_valid;
  assign oLDST_REQ    = ldst_req;
  assign oLDST_ORDER  = ldst_order;
  assign oLDST_MASK   = ldst_mask;
  assign oLDST_RW     = ldst_rw;
  assign oLDST_ADDR   = ldst_addr;
  assign oLDST_DATA   = ldst_data;
  assign oWB_VALID    = wb_valid;
  assign oWB_WRITE    = wb_write;
  assign oWB_DEST     = wb_dest;
  assign oWB_DATA     = wb_data;
  assign oFAULT_VALID = fault_valid;
  assign oFAULT_ADDR  = fault_addr;
  assign oHIT_COUNT   = hit_count;

endmodule
